rl_fifo_1r1w_ctrl: RTL and testbench
====================================

Name: rl_fifo_1r1w_ctrl

Overview:
Synchronous FIFO controller that sequences one 1R1W RAM instance. It is the pointer, flag and handshake logic only; the RAM is instantiated beside it and connected through the ram_* ports.
- Push side writes through the RAM write port.
- Pop side reads through the RAM read port, with 1-cycle registered read latency.
- Used for command, response and trace queues throughout the design.

Parameters:
ABITS, 4, RAM address width; FIFO depth DEPTH = 2**ABITS
DBITS, 32, data width
AFULL_LVL, 2**ABITS-1, almost_full asserts when count >= AFULL_LVL (legal range 1..DEPTH)
AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL (legal range 0..DEPTH-1)

Ports:
rstn  in  1  asynchronous active-low reset
clk  in  1  clock, all logic on rising edge
clr  in  1  synchronous flush; empties the FIFO
push  in  1  write request
d  in  DBITS  write data
pop  in  1  read request
q  out  DBITS  read data; valid when qvalid=1
qvalid  out  1  q holds data of the pop accepted in the previous cycle
empty  out  1  count==0
full  out  1  count==DEPTH
almost_empty  out  1  count<=AEMPTY_LVL
almost_full  out  1  count>=AFULL_LVL
count  out  ABITS+1  number of stored entries
overflow  out  1  1-cycle pulse: push rejected
underflow  out  1  1-cycle pulse: pop rejected
ram_waddr  out  ABITS  to RAM waddr
ram_din  out  DBITS  to RAM din
ram_we  out  1  to RAM we
ram_be  out  (DBITS+7)/8  to RAM be
ram_raddr  out  ABITS  to RAM raddr
ram_dout  in  DBITS  from RAM dout

Behaviour:
Pointers and count:
- wp and rp are ABITS+1 bits; the MSB is the wrap bit.
- count = wp - rp, modulo 2**(ABITS+1).
- full: low bits equal and MSBs differ. empty: wp == rp.

Acceptance rules:
- push_ok = push & ~full & ~clr.
- pop_ok = pop & ~empty & ~clr.
- push while full is rejected even if pop is accepted in the same cycle. This keeps the RAM away from same-address read/write contention when full.
- pop while empty is rejected even if push is accepted in the same cycle.
- A simultaneous push_ok and pop_ok leaves count unchanged; both pointers advance.

RAM drive:
- ram_we = push_ok, combinational.
- ram_waddr = wp[ABITS-1:0].
- ram_din = d.
- ram_be = all ones.
- ram_raddr = rp[ABITS-1:0], driven continuously, including when no pop occurs.

Read timing:
- q = ram_dout, pass-through.
- qvalid is registered pop_ok, so data appears exactly 1 cycle after an accepted pop.
- q content is undefined when qvalid=0.

Write-to-read latency:
- An entry pushed in cycle t is counted, and poppable, in cycle t+1.
- Its data is at q in t+2.

Flags:
- empty, full, almost_* and count are combinational from the pointers, so they update the cycle after the push/pop edge.
- overflow = push & full (registered, 1-cycle pulse).
- underflow = pop & empty (registered, 1-cycle pulse).
- Neither pulse fires when clr=1.

clr:
- On the next edge: wp and rp are set to 0 and qvalid is set to 0.
- push and pop in the same cycle are ignored. RAM contents are untouched.

Reset (rstn=0, asynchronous):
- wp=0, rp=0, qvalid=0, overflow=0, underflow=0.
- Resulting outputs: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (for AFULL_LVL>=1), ram_we=0.
- Reset mid-operation discards all entries. A pop in flight does not produce qvalid after release.

Wrap-around:
- Pointers wrap naturally at 2**(ABITS+1). No special case is needed.

Test Plan:
- Fill/drain, ABITS=2: push 0xA0..0xA3 in 4 consecutive cycles -> full=1, count=4. A 5th push -> overflow pulse, count stays 4. Pop 4 in consecutive cycles -> q sequence A0,A1,A2,A3, each 1 cycle after its pop; then empty=1.
- Simultaneous push and pop at count=2 for 10 cycles with data 0..9 -> count holds 2. Output is the 2 preloaded words, then 0..7 in order. Pointers wrap twice with no corruption.
- Push 0x55 into an empty FIFO while pop=1 in the same cycle -> underflow pulse, count=1. Pop next cycle -> q=0x55 one cycle later, qvalid=1.
- Full FIFO with push=1 and pop=1 in the same cycle -> pop accepted, push rejected with overflow pulse; count=3.
- Thresholds AFULL_LVL=3, AEMPTY_LVL=1: count=1 -> almost_empty=1; count=2 -> almost_empty=0 and almost_full=0; count=3 -> almost_full=1.
- clr at count=3 together with push -> count=0 and empty=1 next cycle, no overflow pulse. Separately, assert rstn=0 mid-pop -> qvalid=0 immediately and all flags at reset values.

Source files
------------

// File: rtl/rl_fifo_1r1w_ctrl_if.sv
// ---------------------------------------------------------------------------
// rl_fifo_1r1w_ctrl_if
// Bundle of every signal between the FIFO controller, its client and the
// 1R1W RAM that sits next to it.
//
//   Client side     : push, d, pop  -> controller
//                     q, qvalid, empty, full, almost_empty, almost_full,
//                     count, overflow, underflow  <- controller
//   RAM side        : ram_waddr, ram_din, ram_we, ram_be, ram_raddr -> RAM
//                     ram_dout <- RAM (registered read, 1-cycle latency)
//
// Modports:
//   master : the environment (client plus RAM) around the controller
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface rl_fifo_1r1w_ctrl_if #(
    parameter int ABITS = 4,
    parameter int DBITS = 32
);
    localparam int BEBITS = (DBITS + 7) / 8;

    // client handshake
    logic               push;
    logic [DBITS-1:0]   d;
    logic               pop;
    logic [DBITS-1:0]   q;
    logic               qvalid;

    // status
    logic               empty;
    logic               full;
    logic               almost_empty;
    logic               almost_full;
    logic [ABITS:0]     count;
    logic               overflow;
    logic               underflow;

    // RAM ports
    logic [ABITS-1:0]   ram_waddr;
    logic [DBITS-1:0]   ram_din;
    logic               ram_we;
    logic [BEBITS-1:0]  ram_be;
    logic [ABITS-1:0]   ram_raddr;
    logic [DBITS-1:0]   ram_dout;

    modport master (
        output push, d, pop, ram_dout,
        input  q, qvalid, empty, full, almost_empty, almost_full, count,
               overflow, underflow,
               ram_waddr, ram_din, ram_we, ram_be, ram_raddr
    );

    modport slave (
        input  push, d, pop, ram_dout,
        output q, qvalid, empty, full, almost_empty, almost_full, count,
               overflow, underflow,
               ram_waddr, ram_din, ram_we, ram_be, ram_raddr
    );
endinterface

// File: rtl/rl_fifo_1r1w_ctrl.sv
// ---------------------------------------------------------------------------
// rl_fifo_1r1w_ctrl
// Pointer, flag and handshake logic of a synchronous FIFO built around one
// external 1R1W RAM with a 1-cycle registered read port.
//
// Ports:
//   clk   : clock, everything on the rising edge
//   rstn  : asynchronous active-low reset
//   clr   : synchronous flush (pointers to zero, qvalid dropped, RAM untouched)
//   bus   : rl_fifo_1r1w_ctrl_if.slave
//             push/d/pop            client requests
//             q/qvalid              read data, valid one cycle after a pop
//             empty/full/almost_*   occupancy flags (from pointers)
//             count                 stored entries
//             overflow/underflow    1-cycle pulses for rejected push/pop
//             ram_*                 write port, read address, read data
// ---------------------------------------------------------------------------
module rl_fifo_1r1w_ctrl #(
    parameter int ABITS      = 4,
    parameter int DBITS      = 32,
    parameter int AFULL_LVL  = 2**ABITS - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    rl_fifo_1r1w_ctrl_if.slave   bus
);
    localparam int BEBITS = (DBITS + 7) / 8;

    // Thresholds resized to the count width; AFULL_LVL may equal DEPTH,
    // which still fits in ABITS+1 bits.
    localparam logic [ABITS:0] AFULL_THR  = (ABITS+1)'(AFULL_LVL);
    localparam logic [ABITS:0] AEMPTY_THR = (ABITS+1)'(AEMPTY_LVL);
    localparam logic [ABITS:0] PTR_ONE    = {{ABITS{1'b0}}, 1'b1};
    localparam logic [ABITS:0] PTR_ZERO   = {(ABITS+1){1'b0}};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ABITS:0] wp_r;
    logic [ABITS:0] rp_r;
    logic           qvalid_r;
    logic           overflow_r;
    logic           underflow_r;

    logic [ABITS:0] count_s;
    logic           empty_s;
    logic           full_s;
    logic           push_ok_s;
    logic           pop_ok_s;

    // Occupancy and acceptance decode from the current pointers
    always_comb begin
        count_s = wp_r - rp_r;
        empty_s = (wp_r == rp_r);
        full_s  = (wp_r[ABITS] != rp_r[ABITS]) &&
                  (wp_r[ABITS-1:0] == rp_r[ABITS-1:0]);
        // A push into a full FIFO stays rejected even if a pop is accepted
        // alongside it, so the RAM never sees a read and write to the same
        // address in one cycle. Likewise a pop from empty is not rescued by
        // a same-cycle push.
        push_ok_s = bus.push & ~full_s & ~clr;
        pop_ok_s  = bus.pop  & ~empty_s & ~clr;
    end

    // Pointer, read-valid and rejection-pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_r        <= PTR_ZERO;
            rp_r        <= PTR_ZERO;
            qvalid_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            wp_r        <= PTR_ZERO;
            rp_r        <= PTR_ZERO;
            qvalid_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            // Pointers wrap naturally at 2**(ABITS+1).
            if (push_ok_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            // The RAM returns the addressed word one edge after the pop.
            qvalid_r    <= pop_ok_s;
            overflow_r  <= bus.push & full_s;
            underflow_r <= bus.pop & empty_s;
        end
    end

    // Client-facing outputs
    assign bus.q            = bus.ram_dout;
    assign bus.qvalid       = qvalid_r;
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.count        = count_s;
    assign bus.almost_empty = (count_s <= AEMPTY_THR);
    assign bus.almost_full  = (count_s >= AFULL_THR);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    // RAM drive; the read address follows rp continuously so the head entry
    // is always being fetched.
    assign bus.ram_we    = push_ok_s;
    assign bus.ram_waddr = wp_r[ABITS-1:0];
    assign bus.ram_din   = bus.d;
    assign bus.ram_be    = {BEBITS{1'b1}};
    assign bus.ram_raddr = rp_r[ABITS-1:0];

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rl_fifo_1r1w_ctrl
// Self-checking bench: a queue-based FIFO model is compared with the DUT on
// every falling edge, directed scenarios pin the model with literal values,
// then randomized traffic runs against the same model.
// ---------------------------------------------------------------------------
module tb_rl_fifo_1r1w_ctrl;
    localparam int ABITS  = 2;
    localparam int DBITS  = 32;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int AEMPTY = 1;

    logic clk;
    logic rstn;
    logic clr;

    int n_checks = 0;
    int n_err    = 0;

    rl_fifo_1r1w_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    rl_fifo_1r1w_ctrl #(
        .ABITS(ABITS), .DBITS(DBITS), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple 1R1W RAM with registered read
    logic [DBITS-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_raddr];
    end

    // Behavioural model state
    logic [DBITS-1:0] mq[$];
    logic             m_qv  = 1'b0;
    logic [DBITS-1:0] m_q   = '0;
    logic             m_ov  = 1'b0;
    logic             m_un  = 1'b0;
    int               wcnt  = 0;
    int               rcnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        m_qv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        wcnt = 0; rcnt = 0;
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic cyc(input logic p, input logic r, input logic [DBITS-1:0] dd, input logic c);
        int n;
        bus.push = p; bus.pop = r; bus.d = dd; clr = c;
        @(posedge clk);
        if (!rstn) begin
            reset_model();
        end else if (c) begin
            reset_model();
        end else begin
            n    = mq.size();
            m_ov = p && (n == DEPTH);
            m_un = r && (n == 0);
            m_qv = r && (n != 0);
            if (m_qv) begin
                m_q = mq.pop_front();
                rcnt++;
            end
            if (p && (n != DEPTH)) begin
                mq.push_back(dd);
                wcnt++;
            end
        end
        #1;
    endtask

    // Compare process: DUT against model every falling edge
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("count",        64'(bus.count),        64'(n));
        chk("empty",        64'(bus.empty),        64'(n == 0));
        chk("full",         64'(bus.full),         64'(n == DEPTH));
        chk("almost_empty", 64'(bus.almost_empty), 64'(n <= AEMPTY));
        chk("almost_full",  64'(bus.almost_full),  64'(n >= AFULL));
        chk("qvalid",       64'(bus.qvalid),       64'(m_qv));
        chk("overflow",     64'(bus.overflow),     64'(m_ov));
        chk("underflow",    64'(bus.underflow),    64'(m_un));
        chk("ram_we",       64'(bus.ram_we),       64'(bus.push && !clr && (n != DEPTH)));
        chk("ram_waddr",    64'(bus.ram_waddr),    64'(wcnt % DEPTH));
        chk("ram_raddr",    64'(bus.ram_raddr),    64'(rcnt % DEPTH));
        chk("ram_din",      64'(bus.ram_din),      64'(bus.d));
        chk("ram_be",       64'(bus.ram_be),       64'hF);
        if (m_qv) chk("q", 64'(bus.q), 64'(m_q));
    end

    initial begin
        rstn = 1'b0; clr = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.d = '0;
        reset_model();
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_aempty", 64'(bus.almost_empty), 64'd1);
        chk("rst_afull", 64'(bus.almost_full), 64'd0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Fill / overflow / drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0);
        chk("fill_count", 64'(bus.count), 64'd4);
        chk("fill_full", 64'(bus.full), 64'd1);
        cyc(1'b1, 1'b0, 32'hA4, 1'b0);
        chk("ovf_pulse", 64'(bus.overflow), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 32'h0, 1'b0);
            chk("drain_qv", 64'(bus.qvalid), 64'd1);
            chk("drain_q", 64'(bus.q), 64'hA0 + 64'(i));
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_empty", 64'(bus.empty), 64'd1);
        chk("drain_qv_off", 64'(bus.qvalid), 64'd0);

        // Steady push+pop at count 2, pointers wrap
        cyc(1'b1, 1'b0, 32'h100, 1'b0);
        cyc(1'b1, 1'b0, 32'h101, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 32'(k), 1'b0);
            chk("pp_count", 64'(bus.count), 64'd2);
            chk("pp_q", 64'(bus.q), (k < 2) ? 64'h100 + 64'(k) : 64'(k - 2));
        end
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("pp_tail8", 64'(bus.q), 64'd8);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("pp_tail9", 64'(bus.q), 64'd9);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Push into empty with pop: pop rejected
        cyc(1'b1, 1'b1, 32'h55, 1'b0);
        chk("unf_pulse", 64'(bus.underflow), 64'd1);
        chk("unf_count", 64'(bus.count), 64'd1);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("unf_qv", 64'(bus.qvalid), 64'd1);
        chk("unf_q", 64'(bus.q), 64'h55);

        // Full with push+pop: pop taken, push rejected
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hB0 + 32'(i), 1'b0);
        cyc(1'b1, 1'b1, 32'hBB, 1'b0);
        chk("fpp_ovf", 64'(bus.overflow), 64'd1);
        chk("fpp_count", 64'(bus.count), 64'd3);
        chk("fpp_q", 64'(bus.q), 64'hB0);

        // Thresholds
        chk("thr3_afull", 64'(bus.almost_full), 64'd1);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("thr2_afull", 64'(bus.almost_full), 64'd0);
        chk("thr2_aempty", 64'(bus.almost_empty), 64'd0);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("thr1_aempty", 64'(bus.almost_empty), 64'd1);

        // clr at count 3 with push
        cyc(1'b1, 1'b0, 32'hC1, 1'b0);
        cyc(1'b1, 1'b0, 32'hC2, 1'b0);
        chk("clr_pre_count", 64'(bus.count), 64'd3);
        cyc(1'b1, 1'b0, 32'hCC, 1'b1);
        chk("clr_count", 64'(bus.count), 64'd0);
        chk("clr_empty", 64'(bus.empty), 64'd1);
        chk("clr_ovf", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hD0 + 32'(i), 1'b0);
        cyc(1'b1, 1'b1, 32'hDD, 1'b1);
        chk("clrf_ovf", 64'(bus.overflow), 64'd0);
        chk("clrf_unf", 64'(bus.underflow), 64'd0);
        chk("clrf_qv", 64'(bus.qvalid), 64'd0);

        // Asynchronous reset with a pop in flight
        cyc(1'b1, 1'b0, 32'h71, 1'b0);
        cyc(1'b1, 1'b0, 32'h72, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("mrst_qv_before", 64'(bus.qvalid), 64'd1);
        rstn = 1'b0;
        reset_model();
        #1;
        chk("mrst_qv", 64'(bus.qvalid), 64'd0);
        chk("mrst_count", 64'(bus.count), 64'd0);
        chk("mrst_empty", 64'(bus.empty), 64'd1);
        chk("mrst_full", 64'(bus.full), 64'd0);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("mrst_qv_after", 64'(bus.qvalid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
